// File: rtl/final_out_pkg.sv
// Shared defaults, beat classification encoding and flag bit positions
// for the fixed-point to OW-bit output converter.
package final_out_pkg;

  localparam int ZW_DEF   = 28;
  localparam int EW_DEF   = 5;
  localparam int OW_DEF   = 16;
  localparam int BIAS_DEF = 15;
  localparam int CW_DEF   = 16;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_UNF  = 2'd1,
    CLS_OVF  = 2'd2
  } cls_t;

  localparam int FLAG_UNF = 0;
  localparam int FLAG_OVF = 1;

  function automatic logic [1:0] cls_flags(cls_t c);
    logic [1:0] f;
    f = 2'b00;
    if (c == CLS_UNF) f[FLAG_UNF] = 1'b1;
    if (c == CLS_OVF) f[FLAG_OVF] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/final_out_stream_if.sv
// Input beat channel plus output beat channel of the converter.
// master = producer/consumer side, slave = converter side.
interface final_out_stream_if
  import final_out_pkg::*;
#(
  parameter int ZW = ZW_DEF,
  parameter int EW = EW_DEF,
  parameter int OW = OW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [ZW-1:0] z;
  logic [EW:0]   a_e;
  logic          round_en;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_flags;

  modport master (
    output in_valid, z, a_e, round_en, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, z, a_e, round_en, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/final_out_classify.sv
// Combinational front end: classifies the exponent and splits z into the
// kept OW-bit field and the first dropped (rounding) bit.
module final_out_classify
  import final_out_pkg::*;
#(
  parameter int ZW   = ZW_DEF,
  parameter int EW   = EW_DEF,
  parameter int OW   = OW_DEF,
  parameter int BIAS = BIAS_DEF
) (
  input  logic [ZW-1:0] z_i,
  input  logic [EW:0]   a_e_i,
  output cls_t          cls_o,
  output logic [OW-1:0] trunc_o,
  output logic          rbit_o
);

  localparam int FRAC = ZW - OW;
  localparam logic [EW-1:0] BIAS_M = EW'(BIAS);

  logic          sign;
  logic [EW-1:0] mag;
  logic          unused_lo;

  assign sign      = a_e_i[EW];
  assign mag       = a_e_i[EW-1:0];
  assign trunc_o   = z_i[ZW-1:FRAC];
  assign rbit_o    = z_i[FRAC-1];
  // Bits below the rounding bit never influence the result.
  assign unused_lo = ^z_i[FRAC-2:0];

  always_comb begin
    cls_o = CLS_NORM;
    if (sign && (mag == BIAS_M)) begin
      cls_o = CLS_UNF;
    end else if (!sign && (mag > BIAS_M)) begin
      cls_o = CLS_OVF;
    end
  end

endmodule

// File: rtl/final_out_stream.sv
// Two-stage converter z/a_e -> saturated OW-bit value with {ovf,unf} flags,
// 2-cycle latency; both stages stall together when the output is held.
module final_out_stream
  import final_out_pkg::*;
#(
  parameter int ZW   = ZW_DEF,
  parameter int EW   = EW_DEF,
  parameter int OW   = OW_DEF,
  parameter int BIAS = BIAS_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  final_out_stream_if.slave    bus,
  input  logic                 clear_cnt,
  output logic [CW-1:0]        ovf_cnt,
  output logic [CW-1:0]        unf_cnt
);

  cls_t          cls_c;
  logic [OW-1:0] trunc_c;
  logic          rbit_c;

  final_out_classify #(
    .ZW(ZW), .EW(EW), .OW(OW), .BIAS(BIAS)
  ) u_classify (
    .z_i     (bus.z),
    .a_e_i   (bus.a_e),
    .cls_o   (cls_c),
    .trunc_o (trunc_c),
    .rbit_o  (rbit_c)
  );

  logic          s1_vld_q,   s1_vld_d;
  cls_t          s1_cls_q,   s1_cls_d;
  logic [OW-1:0] s1_trunc_q, s1_trunc_d;
  logic          s1_rnd_q,   s1_rnd_d;
  logic          s2_vld_q,   s2_vld_d;
  logic [OW-1:0] s2_data_q,  s2_data_d;
  logic [1:0]    s2_flags_q, s2_flags_d;
  logic [CW-1:0] ovf_cnt_q,  ovf_cnt_d;
  logic [CW-1:0] unf_cnt_q,  unf_cnt_d;

  logic          advance;
  logic          deliver;
  logic [OW:0]   sum;

  assign advance = bus.out_ready | ~s2_vld_q;
  assign deliver = s2_vld_q & bus.out_ready;
  assign sum     = {1'b0, s1_trunc_q} + {{OW{1'b0}}, s1_rnd_q};

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_cls_d   = s1_cls_q;
    s1_trunc_d = s1_trunc_q;
    s1_rnd_d   = s1_rnd_q;
    s2_vld_d   = s2_vld_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (advance) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_cls_d   = cls_c;
        s1_trunc_d = trunc_c;
        s1_rnd_d   = rbit_c & bus.round_en;
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_flags_d = cls_flags(s1_cls_q);
        case (s1_cls_q)
          CLS_UNF: s2_data_d = '0;
          CLS_OVF: s2_data_d = '1;
          default: begin
            // Rounding carry out of the kept field saturates like an overflow.
            if (sum[OW]) begin
              s2_data_d  = '1;
              s2_flags_d = cls_flags(CLS_OVF);
            end else begin
              s2_data_d = sum[OW-1:0];
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (clear_cnt) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else if (deliver) begin
      if (s2_flags_q[FLAG_OVF] && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CW'(1);
      if (s2_flags_q[FLAG_UNF] && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_cls_q   <= CLS_NORM;
      s1_trunc_q <= '0;
      s1_rnd_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= 2'b00;
      ovf_cnt_q  <= '0;
      unf_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_cls_q   <= s1_cls_d;
      s1_trunc_q <= s1_trunc_d;
      s1_rnd_q   <= s1_rnd_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
      ovf_cnt_q  <= ovf_cnt_d;
      unf_cnt_q  <= unf_cnt_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_flags = s2_flags_q;
  assign ovf_cnt       = ovf_cnt_q;
  assign unf_cnt       = unf_cnt_q;

endmodule

// File: tb/tb_final_out_stream.sv
// Directed bench for final_out_stream: conversion cases, backpressure,
// throughput, counter saturation/clear and mid-stream reset.
module tb_final_out_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_cnt = 1'b0;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;
  int          n_assert = 0;
  int          n_fail = 0;

  final_out_stream_if bus ();

  final_out_stream dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clear_cnt (clear_cnt),
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] ae, input logic [27:0] zz, input logic rnd);
    bus.in_valid = 1'b1;
    bus.a_e      = ae;
    bus.z        = zz;
    bus.round_en = rnd;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts edges since the beat was accepted.
  task automatic expect_beat(input string tag, input logic [15:0] d, input logic [1:0] f,
                             input int exp_lat);
    int lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " valid"}, bus.out_valid, 1);
    check({tag, " data"}, bus.out_data, d);
    check({tag, " flags"}, bus.out_flags, f);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
  endtask

  // Streams n NORM beats; output is held off for the first `stall` cycles.
  task automatic run_stream(input string tag, input int n, input int stall,
                            input logic [15:0] base, input logic rnd, input int exp_cycles);
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    while (cyc < 60 && rcv < n) begin
      bus.out_ready = (cyc >= stall);
      bus.in_valid  = (sent < n);
      bus.a_e       = 6'b000000;
      bus.z         = {base + 16'(sent), 12'h800};
      bus.round_en  = rnd;
      #1;
      if (stall > 0 && cyc == stall - 1) begin
        check({tag, " in_ready low"}, bus.in_ready, 0);
        check({tag, " held beats"}, sent, 2);
      end
      if (cyc >= 2 && cyc < stall) begin
        check({tag, " hold valid"}, bus.out_valid, 1);
        check({tag, " hold data"}, bus.out_data, base + 16'(rnd));
      end
      if (bus.out_valid && bus.out_ready) begin
        check({tag, " order"}, bus.out_data, base + 16'(rcv) + 16'(rnd));
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, " delivered"}, rcv, n);
    check({tag, " cycles"}, cyc, exp_cycles);
  endtask

  initial begin
    logic seen_stale;
    bus.in_valid  = 1'b0;
    bus.z         = '0;
    bus.a_e       = '0;
    bus.round_en  = 1'b0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst out_flags", bus.out_flags, 0);
    check("rst ovf_cnt", ovf_cnt, 0);
    check("rst unf_cnt", unf_cnt, 0);
    reset = 1'b0;
    #1;
    check("rst in_ready", bus.in_ready, 1);

    send(6'b001111, 28'hABCDEF1, 1'b0);
    expect_beat("trunc", 16'hABCD, 2'b00, 2);
    send(6'b001111, 28'hABCDEF1, 1'b1);
    expect_beat("round", 16'hABCE, 2'b00, 2);

    send(6'b010000, 28'h1234567, 1'b1);
    expect_beat("ovf", 16'hFFFF, 2'b10, 0);
    tick();
    check("ovf cnt1", ovf_cnt, 1);
    check("ovf unf0", unf_cnt, 0);

    send(6'b101111, 28'h1234567, 1'b0);
    expect_beat("unf", 16'h0000, 2'b01, 0);
    tick();
    check("unf cnt1", unf_cnt, 1);

    send(6'b110000, 28'h1234867, 1'b1);
    expect_beat("neg norm", 16'h1235, 2'b00, 0);

    send(6'b000000, 28'hFFFF800, 1'b1);
    expect_beat("round carry", 16'hFFFF, 2'b10, 0);
    tick();
    check("carry ovf cnt", ovf_cnt, 2);
    send(6'b000000, 28'hFFFF800, 1'b0);
    expect_beat("trunc max", 16'hFFFF, 2'b00, 0);
    tick();
    check("trunc max cnt", ovf_cnt, 2);

    run_stream("bp", 4, 7, 16'hC0DE, 1'b0, 11);
    run_stream("tput", 8, 0, 16'h2000, 1'b1, 10);

    // Push ovf_cnt from 2 up to its ceiling.
    bus.out_ready = 1'b1;
    bus.a_e       = 6'b010000;
    bus.z         = '0;
    bus.round_en  = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("sat reach", ovf_cnt, 16'hFFFF);
    check("sat unf", unf_cnt, 1);
    send(6'b010000, 28'h0, 1'b0);
    expect_beat("sat beat", 16'hFFFF, 2'b10, 0);
    tick();
    check("sat hold", ovf_cnt, 16'hFFFF);

    send(6'b010000, 28'h0, 1'b0);
    expect_beat("clr beat", 16'hFFFF, 2'b10, 0);
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    check("clr ovf", ovf_cnt, 0);
    check("clr unf", unf_cnt, 0);

    send(6'b101111, 28'h0, 1'b0);
    expect_beat("pre rst unf", 16'h0000, 2'b01, 0);
    tick();
    check("pre rst unf cnt", unf_cnt, 1);

    bus.out_ready = 1'b0;
    bus.a_e       = 6'b010000;
    bus.in_valid  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("inflight valid", bus.out_valid, 1);
    reset = 1'b1;
    tick();
    check("mid rst out_valid", bus.out_valid, 0);
    check("mid rst ovf", ovf_cnt, 0);
    check("mid rst unf", unf_cnt, 0);
    check("mid rst data", bus.out_data, 0);
    reset = 1'b0;
    #1;
    check("post rst in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    seen_stale = 1'b0;
    repeat (6) begin
      tick();
      if (bus.out_valid) seen_stale = 1'b1;
    end
    check("no stale beat", seen_stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
